demux1x2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer; the routing counterpart of the team's 2x1 mux DUT.
- Accepts one DATA_W word per valid/ready handshake on a single input. Steers each word to output 0 or output 1 according to in_sel, which is sampled with the word.
- Each output has a one-entry output register. Optional per-channel transfer counters are provided for scoreboard cross-checking in the TB environment.

---
 rtl/demux1x2_stream_if.sv | 35 +++
 rtl/demux1x2_stream.sv | 149 ++++++++++++++
 tb/tb_demux1x2_stream.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/demux1x2_stream_if.sv
// ---------------------------------------------------------------------------
// demux1x2_stream_if
// Handshake/data bundle for the 1-to-2 stream demultiplexer.
//   in_valid / in_ready / in_data / in_sel : single input stream, in_sel picks
//                                            the destination channel
//   out0_valid / out0_ready / out0_data    : output channel 0
//   out1_valid / out1_ready / out1_data    : output channel 1
// Modports:
//   master : producer/consumer side (drives input stream and output readies)
//   slave  : demultiplexer side
// ---------------------------------------------------------------------------
interface demux1x2_stream_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux1x2_stream.sv
// ---------------------------------------------------------------------------
// demux1x2_stream
// Registered 1-to-2 stream demultiplexer. Each accepted input word is steered
// to output 0 or 1 by in_sel (sampled with the word) and lands in that
// channel's one-entry output register one cycle later.
// Ports:
//   clk  : clock, all state changes on rising edge
//   rst  : synchronous active-high reset (discards held words, clears counters)
//   bus  : demux1x2_stream_if.slave, input stream and both output streams
//   cnt0 : words delivered on out0 (modulo 2^CNT_W)
//   cnt1 : words delivered on out1 (modulo 2^CNT_W)
// Build option:
//   DEMUX1X2_STATS_EN : when defined, cnt0/cnt1 are real transfer counters;
//                       otherwise they are tied to zero and no counter
//                       registers exist.
// ---------------------------------------------------------------------------
module demux1x2_stream #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux1x2_stream_if.slave    bus,
    output logic [CNT_W-1:0]    cnt0,
    output logic [CNT_W-1:0]    cnt1
);

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    ch_state_t         state0_r;
    ch_state_t         state1_r;
    ch_state_t         state0_nxt_s;
    ch_state_t         state1_nxt_s;
    logic [DATA_W-1:0] data0_r;
    logic [DATA_W-1:0] data1_r;

    logic ch0_free_s;
    logic ch1_free_s;
    logic in_ready_s;
    logic in_xfer_s;
    logic load0_s;
    logic load1_s;
    logic drain0_s;
    logic drain1_s;

    // Per-channel next state: a load always wins (covers drain+load while
    // FULL, so no bubble); a drain without a load empties the channel.
    function automatic ch_state_t ch_next(input ch_state_t cur,
                                          input logic load,
                                          input logic drain);
        ch_state_t nxt;
        nxt = cur;
        case (cur)
            CH_EMPTY: begin
                if (load) nxt = CH_FULL;
                else      nxt = CH_EMPTY;
            end
            CH_FULL: begin
                if (load)       nxt = CH_FULL;
                else if (drain) nxt = CH_EMPTY;
                else            nxt = CH_FULL;
            end
            default: nxt = CH_EMPTY;
        endcase
        return nxt;
    endfunction

    // Handshake decode: ready follows only the selected channel (head-of-line
    // blocking), and loads are qualified by in_valid so idle-cycle sel/data
    // cannot disturb either channel.
    always_comb begin
        ch0_free_s = (state0_r == CH_EMPTY) | bus.out0_ready;
        ch1_free_s = (state1_r == CH_EMPTY) | bus.out1_ready;
        if (bus.in_sel == 1'b1) begin
            in_ready_s = ch1_free_s;
        end else begin
            in_ready_s = ch0_free_s;
        end
        in_xfer_s = bus.in_valid & in_ready_s;
        load0_s   = in_xfer_s & ~bus.in_sel;
        load1_s   = in_xfer_s &  bus.in_sel;
        drain0_s  = (state0_r == CH_FULL) & bus.out0_ready;
        drain1_s  = (state1_r == CH_FULL) & bus.out1_ready;
    end

    // Next-state selection for both channel FSMs.
    always_comb begin
        state0_nxt_s = ch_next(state0_r, load0_s, drain0_s);
        state1_nxt_s = ch_next(state1_r, load1_s, drain1_s);
    end

    // Channel state registers; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state0_r <= CH_EMPTY;
            state1_r <= CH_EMPTY;
        end else begin
            state0_r <= state0_nxt_s;
            state1_r <= state1_nxt_s;
        end
    end

    // Output data registers; data is held (not cleared) after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            data0_r <= {DATA_W{1'b0}};
            data1_r <= {DATA_W{1'b0}};
        end else begin
            if (load0_s) data0_r <= bus.in_data;
            else         data0_r <= data0_r;
            if (load1_s) data1_r <= bus.in_data;
            else         data1_r <= data1_r;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out0_valid = (state0_r == CH_FULL);
    assign bus.out0_data  = data0_r;
    assign bus.out1_valid = (state1_r == CH_FULL);
    assign bus.out1_data  = data1_r;

`ifdef DEMUX1X2_STATS_EN
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Delivered-word counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (drain0_s) cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else          cnt0_r <= cnt0_r;
            if (drain1_s) cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else          cnt1_r <= cnt1_r;
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`else
    assign cnt0 = {CNT_W{1'b0}};
    assign cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1x2_stream
// Directed, table-driven bench for demux1x2_stream (DATA_W=4, CNT_W=8).
// Each table row gives the inputs for one cycle, the expected in_ready during
// that cycle, and the expected registered outputs just after the edge.
// A hand-written 256-word stream on channel 1 covers throughput and wrap.
// ---------------------------------------------------------------------------
module tb_demux1x2_stream;

`ifdef DEMUX1X2_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [3:0] d;
        logic       sel;
        logic       r0;
        logic       r1;
        logic       chk_rdy;
        logic       rdy;
        logic       o0v;
        logic [3:0] o0d;
        logic       o1v;
        logic [3:0] o1d;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    localparam int NVEC = 16;

    logic       clk;
    logic       rst;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    int         n_vec;
    int         n_err;
    vec_t       vecs [NVEC];

    demux1x2_stream_if #(.DATA_W(4)) bus ();

    demux1x2_stream #(.DATA_W(4), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .cnt0 (cnt0),
        .cnt1 (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [3:0] d,
                         input logic sel, input logic r0, input logic r1);
        rst            = r;
        bus.in_valid   = iv;
        bus.in_data    = d;
        bus.in_sel     = sel;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1);

        //           rst   iv    d      sel   r0    r1    chk   rdy   o0v   o0d    o1v   o1d    c0     c1
        // Reset held two cycles with in_valid high.
        vecs[0]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0, 8'd0};
        // Basic route A -> out0, then drained, counter follows a cycle later.
        vecs[3]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 8'd0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 8'd1, 8'd0};
        // Backpressure and head-of-line blocking.
        vecs[5]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 8'd1, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 8'd1, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 4'hC, 8'd1, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hB, 1'b1, 4'hC, 8'd2, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB, 1'b0, 4'hC, 8'd3, 8'd1};
        // Back-to-back drain+load on out0, no bubble.
        vecs[10] = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h4, 1'b0, 4'hC, 8'd3, 8'd1};
        vecs[11] = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'hC, 8'd4, 8'd1};
        vecs[12] = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 1'b1, 4'h9, 8'd4, 8'd1};
        // Both FULL and stalled: selected channel blocks, idle input ignored.
        vecs[13] = '{1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 4'h9, 8'd4, 8'd1};
        // Reset mid-operation beats the pending drains.
        vecs[14] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0, 8'd0};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0, 8'd0};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].sel, vecs[i].r0, vecs[i].r1);
            #1;
            if (vecs[i].chk_rdy)
                check($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].rdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d out0_valid", i), {31'd0, bus.out0_valid}, {31'd0, vecs[i].o0v});
            check($sformatf("v%0d out0_data", i),  {28'd0, bus.out0_data},  {28'd0, vecs[i].o0d});
            check($sformatf("v%0d out1_valid", i), {31'd0, bus.out1_valid}, {31'd0, vecs[i].o1v});
            check($sformatf("v%0d out1_data", i),  {28'd0, bus.out1_data},  {28'd0, vecs[i].o1d});
            check($sformatf("v%0d cnt0", i), {24'd0, cnt0}, {24'd0, (STATS ? vecs[i].c0 : 8'd0)});
            check($sformatf("v%0d cnt1", i), {24'd0, cnt1}, {24'd0, (STATS ? vecs[i].c1 : 8'd0)});
        end

        // 256 back-to-back words on out1: one per cycle, in order, cnt1 wraps.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idx;
            idx = i[7:0];
            drive(1'b0, 1'b1, idx[3:0], 1'b1, 1'b0, 1'b1);
            #1;
            check($sformatf("s%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("s%0d out1_valid", i), {31'd0, bus.out1_valid}, 32'd1);
            check($sformatf("s%0d out1_data", i),  {28'd0, bus.out1_data},  {28'd0, idx[3:0]});
            check($sformatf("s%0d cnt1", i), {24'd0, cnt1}, {24'd0, (STATS ? idx : 8'd0)});
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("stream end out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        check("stream end out1_data",  {28'd0, bus.out1_data},  32'hF);
        check("stream end out0_valid", {31'd0, bus.out0_valid}, 32'd0);
        check("stream wrap cnt1", {24'd0, cnt1}, 32'd0);
        check("stream cnt0 unchanged", {24'd0, cnt0}, 32'd0);

        // Word stuck in out0 under backpressure is discarded by reset.
        drive(1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("hold out0_data", {28'd0, bus.out0_data}, 32'h6);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("discard out0_valid", {31'd0, bus.out0_valid}, 32'd0);
        check("discard out0_data",  {28'd0, bus.out0_data},  32'd0);
        check("discard cnt0", {24'd0, cnt0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
